fir_stream_feeder: RTL and testbench

// - Upstream-side driver for the folded 8-tap FIR core (en/ready/valid handshake).
// - Buffers signed 8-bit samples from a push interface and issues one sample per FIR ready window.
// - Holds fir_x stable until the matching result arrives, then captures y into a result slot

---
 rtl/fir_stream_feeder.sv | 233 +++++++++++++++++++++++
 tb/tb_fir_stream_feeder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_feeder.sv
// ---------------------------------------------------------------------------
// fir_stream_feeder
//
// Upstream-side driver for the folded 8-tap FIR core. Samples pushed by the
// source are buffered in a small circular FIFO. One sample is issued per FIR
// ready window with a one-cycle fir_en pulse. fir_x is held stable until the
// matching fir_valid arrives. The result is then captured into a single result
// slot with a valid/ready handshake towards the downstream consumer.
//
// Optional feature macro: FEEDER_TIMEOUT_EN
//   When defined, a watchdog counts WAIT cycles. After TIMEOUT cycles without
//   fir_valid, the outstanding sample is abandoned and tmo_err is set (sticky).
//   When undefined, WAIT lasts until fir_valid and tmo_err is tied low.
//
// Parameters
//   DEPTH    input FIFO entries (power of two, >= 2)
//   TIMEOUT  allowed cycles between fir_en and fir_valid (timeout build only)
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   s_data     signed sample from upstream
//   s_push     write s_data into the FIFO this cycle
//   s_full     FIFO full; a push while full (and not popping) is dropped
//   fir_en     one-cycle issue pulse to the FIR core
//   fir_x      sample to the FIR core, stable from fir_en until fir_valid
//   fir_ready  FIR core can accept a sample
//   fir_valid  one-cycle pulse, fir_y holds a result
//   fir_y      signed FIR result
//   m_data     captured result
//   m_valid    m_data valid, held until m_ready
//   m_ready    downstream accepts m_data when m_valid & m_ready
//   busy       a sample is outstanding in the FIR (state WAIT)
//   ovf        sticky: a push was dropped because the FIFO was full
//   tmo_err    sticky timeout flag (always 0 without FEEDER_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module fir_stream_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [7:0] s_data,
  input  logic              s_push,
  output logic              s_full,
  output logic              fir_en,
  output logic signed [7:0] fir_x,
  input  logic              fir_ready,
  input  logic              fir_valid,
  input  logic signed [7:0] fir_y,
  output logic signed [7:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              ovf,
  output logic              tmo_err
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_next_s;

  logic signed [7:0]  mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [AW:0]        count_r;

  logic               fir_en_r;
  logic signed [7:0]  fir_x_r;
  logic signed [7:0]  m_data_r;
  logic               m_valid_r;
  logic               ovf_r;

  logic               empty_s;
  logic               full_s;
  logic               slot_free_s;
  logic               issue_s;
  logic               capture_s;
  logic               push_ok_s;

  assign empty_s     = (count_r == '0);
  assign full_s      = (count_r == DEPTH_C);
  // The slot counts as free when it is empty or is being drained on this edge.
  assign slot_free_s = !m_valid_r || m_ready;
  // A push while full is accepted only when the same edge pops the head.
  assign push_ok_s   = s_push && (!full_s || issue_s);

`ifdef FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt_r;
  logic          tmo_err_r;
  logic          timeout_s;

  // fir_valid on the expiry cycle still wins over the timeout.
  assign timeout_s = (state_r == ST_WAIT) && !fir_valid &&
                     (tmo_cnt_r == TW'(TIMEOUT - 1));

  // Watchdog counter for WAIT and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= '0;
      tmo_err_r <= 1'b0;
    end else begin
      if (issue_s) begin
        tmo_cnt_r <= '0;
      end else if (state_r == ST_WAIT) begin
        tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
      if (timeout_s) begin
        tmo_err_r <= 1'b1;
      end
    end
  end

  assign tmo_err = tmo_err_r;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT > 0);
  assign tmo_err          = 1'b0;
`endif

  // Next-state and issue/capture decode for the feeder FSM.
  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // fir_valid in IDLE is a stray pulse and is ignored.
        if (!empty_s && fir_ready && slot_free_s) begin
          issue_s      = 1'b1;
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (fir_valid) begin
          capture_s    = 1'b1;
          state_next_s = ST_IDLE;
`ifdef FEEDER_TIMEOUT_EN
        end else if (timeout_s) begin
          state_next_s = ST_IDLE;
`endif
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Circular FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'sd0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= s_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, issue_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Issue pulse, held sample, result slot and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fir_en_r  <= 1'b0;
      fir_x_r   <= 8'sd0;
      m_data_r  <= 8'sd0;
      m_valid_r <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      fir_en_r <= issue_s;
      if (issue_s) begin
        fir_x_r <= mem_r[rd_ptr_r];
      end
      // A capture on the same edge as a drain keeps the slot occupied.
      if (capture_s) begin
        m_data_r  <= fir_y;
        m_valid_r <= 1'b1;
      end else if (m_valid_r && m_ready) begin
        m_valid_r <= 1'b0;
      end
      if (s_push && full_s && !issue_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign s_full  = full_s;
  assign fir_en  = fir_en_r;
  assign fir_x   = fir_x_r;
  assign m_data  = m_data_r;
  assign m_valid = m_valid_r;
  assign busy    = (state_r == ST_WAIT);
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_fir_stream_feeder.sv
// ---------------------------------------------------------------------------
// tb_fir_stream_feeder
//
// Drives fir_stream_feeder against a small behavioural FIR core model. The
// model answers y = x + 1 nine cycles after it sees fir_en. Samples pushed by
// the bench are queued as expected fir_x values. Each observed issue moves the
// expected result (x + 1) into a result queue. Each downstream handshake pops
// and compares it.
// ---------------------------------------------------------------------------
module tb_fir_stream_feeder;

  localparam int DEPTH = 4;
  localparam int LAT   = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'd0;
  logic       s_push = 1'b0;
  logic       s_full;
  logic       fir_en;
  logic [7:0] fir_x;
  logic       fir_ready = 1'b0;
  logic       fir_valid = 1'b0;
  logic [7:0] fir_y = 8'd0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic       busy;
  logic       ovf;
  logic       tmo_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_x_q [$];
  logic [7:0] exp_y_q [$];

  bit         ready_en     = 1'b1;
  bit         core_respond = 1'b1;
  bit         core_busy    = 1'b0;
  int         core_cnt     = 0;
  logic [7:0] core_x       = 8'd0;
  bit         outstanding  = 1'b0;
  bit         tmo_prev     = 1'b0;
  int         n_fir_en     = 0;
  int         n_results    = 0;

  always #5 clk = ~clk;

  fir_stream_feeder #(.DEPTH(DEPTH), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_push    (s_push),
    .s_full    (s_full),
    .fir_en    (fir_en),
    .fir_x     (fir_x),
    .fir_ready (fir_ready),
    .fir_valid (fir_valid),
    .fir_y     (fir_y),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy),
    .ovf       (ovf),
    .tmo_err   (tmo_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sample(input logic [7:0] v, input bit accept);
    s_data = v;
    s_push = 1'b1;
    if (accept) exp_x_q.push_back(v);
    tick();
    s_push = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (exp_x_q.size() == 0 && exp_y_q.size() == 0 && !m_valid) done = 1'b1;
    end
    check_eq(tag, done, 1);
  endtask

  // Monitor (scoreboard side) followed by the behavioural FIR core, both on the falling edge.
  always @(negedge clk) begin
    logic [7:0] x_t;
    logic [7:0] y_t;
    if (!rst) begin
      if (fir_en) begin
        n_fir_en++;
        check_eq("single_outstanding", outstanding, 0);
        outstanding = 1'b1;
        if (exp_x_q.size() == 0) begin
          check_eq("issue_without_sample", exp_x_q.size(), 1);
        end else begin
          x_t = exp_x_q.pop_front();
          check_eq("fir_x", fir_x, x_t);
          y_t = x_t + 8'd1;
          if (core_respond) exp_y_q.push_back(y_t);
        end
      end
      if (fir_valid) outstanding = 1'b0;
      if (tmo_err && !tmo_prev) outstanding = 1'b0;
      tmo_prev = tmo_err;
      if (m_valid && m_ready) begin
        n_results++;
        if (exp_y_q.size() == 0) begin
          check_eq("result_without_issue", exp_y_q.size(), 1);
        end else begin
          y_t = exp_y_q.pop_front();
          check_eq("m_data", m_data, y_t);
        end
      end
    end
    fir_valid = 1'b0;
    if (core_busy) begin
      core_cnt--;
      if (core_cnt == 0) begin
        core_busy = 1'b0;
        if (core_respond) begin
          fir_valid = 1'b1;
          fir_y     = core_x + 8'd1;
        end
      end
    end
    if (fir_en && !rst) begin
      core_busy = 1'b1;
      core_cnt  = LAT;
      core_x    = fir_x;
    end
    fir_ready = ready_en && !core_busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    bit seen;

    // Reset state.
    rst = 1'b1;
    repeat (3) tick();
    check_eq("reset_outputs", {s_full, fir_en, fir_x, m_data, m_valid, busy, ovf, tmo_err}, 0);
    rst = 1'b0;
    tick();

    // Single sample: issue latency, fir_x, busy, one-cycle fir_en.
    push_sample(8'd5, 1'b1);
    check_eq("no_issue_on_push_edge", fir_en, 0);
    tick();
    check_eq("fir_en_pulse", fir_en, 1);
    check_eq("fir_x_first", fir_x, 8'd5);
    check_eq("busy_in_wait", busy, 1);
    tick();
    check_eq("fir_en_one_cycle", fir_en, 0);
    check_eq("busy_held", busy, 1);
    wait_drain("drain_single");

    // Back-to-back samples 1,2,3.
    snap = n_results;
    push_sample(8'd1, 1'b1);
    push_sample(8'd2, 1'b1);
    push_sample(8'd3, 1'b1);
    wait_drain("drain_burst");
    check_eq("burst_result_count", n_results - snap, 3);

    // Result held with m_ready low blocks further issue.
    m_ready = 1'b0;
    push_sample(8'd10, 1'b1);
    push_sample(8'd11, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (m_valid) seen = 1'b1;
    end
    check_eq("result_arrives", seen, 1);
    snap = n_fir_en;
    repeat (20) tick();
    check_eq("no_issue_while_slot_full", n_fir_en - snap, 0);
    check_eq("m_valid_held", m_valid, 1);
    check_eq("m_data_held", m_data, 8'd11);
    m_ready = 1'b1;
    tick();
    check_eq("issue_on_drain_edge", fir_en, 1);
    check_eq("fir_x_after_drain", fir_x, 8'd11);
    check_eq("slot_drained", m_valid, 0);
    wait_drain("drain_held");

    // Fill with fir_ready low, overflow, then push and pop while full.
    ready_en = 1'b0;
    tick();
    push_sample(8'd20, 1'b1);
    push_sample(8'hEB, 1'b1);
    push_sample(8'd22, 1'b1);
    check_eq("not_full_at_3", s_full, 0);
    push_sample(8'd23, 1'b1);
    check_eq("full_at_depth", s_full, 1);
    check_eq("ovf_clear_before_drop", ovf, 0);
    push_sample(8'd99, 1'b0);
    check_eq("ovf_on_drop", ovf, 1);
    check_eq("still_full", s_full, 1);
    ready_en = 1'b1;
    push_sample(8'd24, 1'b1);
    check_eq("full_after_push_pop", s_full, 1);
    check_eq("pop_while_full", fir_en, 1);
    check_eq("fir_x_oldest", fir_x, 8'd20);
    wait_drain("drain_overflow");
    check_eq("ovf_sticky", ovf, 1);

    // Reset while in WAIT with two samples queued.
    push_sample(8'd30, 1'b1);
    push_sample(8'd31, 1'b1);
    push_sample(8'd32, 1'b1);
    tick();
    tick();
    check_eq("busy_before_reset", busy, 1);
    rst = 1'b1;
    tick();
    check_eq("mid_reset_outputs", {s_full, fir_en, fir_x, m_data, m_valid, busy, ovf, tmo_err}, 0);
    exp_x_q.delete();
    exp_y_q.delete();
    outstanding = 1'b0;
    rst = 1'b0;
    snap = n_fir_en;
    repeat (15) tick();
    check_eq("stray_valid_ignored", m_valid, 0);
    check_eq("idle_after_reset", busy, 0);
    check_eq("fifo_flushed", n_fir_en - snap, 0);
    push_sample(8'd40, 1'b1);
    wait_drain("drain_after_reset");

    // Withheld fir_valid.
    core_respond = 1'b0;
    push_sample(8'd50, 1'b1);
    push_sample(8'd51, 1'b1);
    check_eq("timeout_issue", fir_en, 1);
`ifdef FEEDER_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (!busy || tmo_err) seen = 1'b1;
    end
    check_eq("no_early_timeout", seen, 0);
    tick();
    check_eq("tmo_err_set", tmo_err, 1);
    check_eq("busy_after_timeout", busy, 0);
    core_respond = 1'b1;
    tick();
    check_eq("next_issue_after_timeout", fir_en, 1);
    check_eq("next_x_after_timeout", fir_x, 8'd51);
    wait_drain("drain_after_timeout");
    check_eq("tmo_err_sticky", tmo_err, 1);
`else
    repeat (80) tick();
    check_eq("wait_indefinite", busy, 1);
    check_eq("tmo_err_tied_low", tmo_err, 0);
    rst = 1'b1;
    tick();
    exp_x_q.delete();
    exp_y_q.delete();
    outstanding = 1'b0;
    rst = 1'b0;
    core_respond = 1'b1;
    repeat (15) tick();
    check_eq("recovered_idle", busy, 0);
`endif

    check_eq("scoreboard_empty", exp_x_q.size() + exp_y_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
